// File: rtl/dekatron_pkg.sv
// Shared definitions for the dekatron CPU console path: BCD word geometry,
// UART FSM state encoding and the substitute character for bad digits.
package dekatron_pkg;

   localparam int unsigned DEKATRON_WIDTH    = 4;
   localparam int unsigned DATA_DEKATRON_NUM = 3;

   localparam logic [7:0]  BAD_DIGIT_CHAR    = 8'h3F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read (dout is the current head).
// Ports:
//   Clk, Rst     : clock, synchronous active-high reset
//   push, din    : write request and data (ignored when full)
//   pop          : read request, advances the head (ignored when empty)
//   dout         : head entry
//   full, empty  : occupancy flags
//   count        : number of stored entries (0..DEPTH)
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Occupancy update; push+pop together leaves the count unchanged
   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointers are exactly log2(DEPTH) bits and wrap naturally
   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Storage needs no reset; only valid entries are ever read
   always_ff @(posedge Clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/cout_console_tx.sv
// Console transmitter fed by the CPU Cout strobe: converts the BCD Data word
// to a byte (value mod 256), queues it and sends it as 8N1 UART.
// Ports:
//   Clk, Rst  : clock, synchronous active-high reset
//   Cout      : one-cycle strobe, Data valid in the same cycle
//   Data      : BCD cell value, hundreds/tens/ones (ones in the LSBs)
//   Ready     : FIFO can accept one more byte (sample before Cout)
//   Overflow  : sticky, a strobe was dropped because the FIFO was full
//   BadDigit  : sticky, a captured digit was above 9
//   TxBusy    : a frame is in progress
//   Tx        : UART line, idles high
module cout_console_tx
   import dekatron_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                                        Clk,
   input  logic                                        Rst,
   input  logic                                        Cout,
   input  logic [DATA_DEKATRON_NUM*DEKATRON_WIDTH-1:0] Data,
   output logic                                        Ready,
   output logic                                        Overflow,
   output logic                                        BadDigit,
   output logic                                        TxBusy,
   output logic                                        Tx
);

   localparam int unsigned SUM_W  = 10;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OCC_W  = CNT_W + 1;
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

   // ---------------- convert stage ----------------
   logic [SUM_W-1:0]          conv_sum_c;
   logic                      conv_bad_c;
   logic [DEKATRON_WIDTH-1:0] digit_c;
   logic                      cvalid_q;
   logic [7:0]                cbyte_q;
   logic                      bad_q;
   logic                      ovf_q;
   logic                      ready_q;
   logic                      ready_d;
   logic [OCC_W-1:0]          occ_next_c;

   // ---------------- FIFO / UART ----------------
   logic              fifo_push;
   logic              fifo_pop;
   logic [7:0]        fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   uart_state_t       state_q;
   uart_state_t       state_d;
   logic [BAUD_W-1:0] baud_cnt_q;
   logic [2:0]        bit_cnt_q;
   logic [7:0]        shift_q;
   logic              tx_q;
   logic              busy_q;
   logic              tx_c;
   logic              baud_done;
   logic              bit_last;

   // Horner evaluation of the BCD word; the 10-bit wrap is harmless since
   // only the low 8 bits are kept
   always_comb begin
      conv_sum_c = '0;
      conv_bad_c = 1'b0;
      digit_c    = '0;
      for (int i = int'(DATA_DEKATRON_NUM) - 1; i >= 0; i--) begin
         digit_c = Data[i*int'(DEKATRON_WIDTH) +: DEKATRON_WIDTH];
         if (digit_c > DEKATRON_WIDTH'(9)) conv_bad_c = 1'b1;
         conv_sum_c = SUM_W'(conv_sum_c * SUM_W'(10)) + SUM_W'(digit_c);
      end
   end

   // A stage-C byte that meets a full FIFO is lost, even if a pop happens now
   assign fifo_push = cvalid_q && !fifo_full;

   // Ready is registered from the next-cycle occupancy so it equals
   // (count + stage-C valid) < FIFO_DEPTH in every cycle
   always_comb begin
      occ_next_c = OCC_W'(fifo_count) + OCC_W'(fifo_push)
                 - OCC_W'(fifo_pop) + OCC_W'(Cout);
      ready_d    = (occ_next_c < OCC_W'(FIFO_DEPTH));
   end

   // Convert stage register, sticky flags and Ready
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cvalid_q <= 1'b0;
         cbyte_q  <= '0;
         bad_q    <= 1'b0;
         ovf_q    <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         cvalid_q <= Cout;
         ready_q  <= ready_d;
         if (Cout) cbyte_q <= conv_bad_c ? BAD_DIGIT_CHAR : 8'(conv_sum_c);
         if (Cout && conv_bad_c)   bad_q <= 1'b1;
         if (cvalid_q && fifo_full) ovf_q <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clk   (Clk),
      .Rst   (Rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (cbyte_q),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign baud_done = (baud_cnt_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign bit_last  = (bit_cnt_q == 3'd7);

   // UART state register
   always_ff @(posedge Clk) begin
      if (Rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // UART next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty)            state_d = START;
         START:   if (baud_done)              state_d = DATA;
         DATA:    if (baud_done && bit_last)  state_d = STOP;
         STOP:    if (baud_done)              state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   // UART outputs: head pop and the line level for the current state
   always_comb begin
      fifo_pop = 1'b0;
      tx_c     = 1'b1;
      case (state_q)
         IDLE:    fifo_pop = !fifo_empty;
         START:   tx_c     = 1'b0;
         DATA:    tx_c     = shift_q[bit_cnt_q];
         STOP:    tx_c     = 1'b1;
         default: tx_c     = 1'b1;
      endcase
   end

   // UART datapath; the line register lags the state by one cycle, so the
   // start bit appears one edge after the pop
   always_ff @(posedge Clk) begin
      if (Rst) begin
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         tx_q   <= tx_c;
         busy_q <= (state_d != IDLE);
         if (fifo_pop) shift_q <= fifo_dout;
         if (state_q == IDLE || baud_done) baud_cnt_q <= '0;
         else                              baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
         if (state_q != DATA) bit_cnt_q <= '0;
         else if (baud_done)  bit_cnt_q <= bit_cnt_q + 3'd1;
      end
   end

   assign Ready    = ready_q;
   assign Overflow = ovf_q;
   assign BadDigit = bad_q;
   assign TxBusy   = busy_q;
   assign Tx       = tx_q;

endmodule

// File: tb/tb_cout_console_tx.sv
// Directed bench for cout_console_tx (FIFO_DEPTH=4, CLKS_PER_BIT=4).
module tb_cout_console_tx;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;

   logic        Clk  = 1'b0;
   logic        Rst  = 1'b1;
   logic        Cout = 1'b0;
   logic [11:0] Data = '0;
   logic        Ready;
   logic        Overflow;
   logic        BadDigit;
   logic        TxBusy;
   logic        Tx;

   int n_cmp  = 0;
   int n_fail = 0;
   int frame_err = 0;
   logic [7:0] rx_q [$];

   always #5 Clk = ~Clk;

   cout_console_tx #(
      .FIFO_DEPTH   (DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Cout     (Cout),
      .Data     (Data),
      .Ready    (Ready),
      .Overflow (Overflow),
      .BadDigit (BadDigit),
      .TxBusy   (TxBusy),
      .Tx       (Tx)
   );

   // UART receiver: samples mid-bit on falling clock edges, drops frames cut by reset
   initial begin : monitor
      logic       prev;
      logic [7:0] b;
      bit         abort;
      prev = 1'b1;
      forever begin
         @(negedge Clk);
         if (!Rst && prev === 1'b1 && Tx === 1'b0) begin
            abort = 1'b0;
            b     = '0;
            for (int k = 0; k < int'(CPB/2); k++) begin
               @(negedge Clk);
               if (Rst) abort = 1'b1;
            end
            if (!abort && Tx !== 1'b0) frame_err++;
            for (int i = 0; i < 8; i++) begin
               for (int k = 0; k < int'(CPB); k++) begin
                  @(negedge Clk);
                  if (Rst) abort = 1'b1;
               end
               b[i] = Tx;
            end
            for (int k = 0; k < int'(CPB); k++) begin
               @(negedge Clk);
               if (Rst) abort = 1'b1;
            end
            if (!abort && Tx !== 1'b1) frame_err++;
            if (!abort) rx_q.push_back(b);
         end
         prev = Tx;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [11:0] bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic do_reset();
      @(negedge Clk);
      Rst  = 1'b1;
      Cout = 1'b0;
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
   endtask

   task automatic send_char(input logic [11:0] d);
      @(negedge Clk);
      Cout = 1'b1;
      Data = d;
      @(negedge Clk);
      Cout = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int limit);
      int cyc;
      cyc = 0;
      while (rx_q.size() < n && cyc < limit) begin
         @(negedge Clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (Tx !== 1'b1)       begin n_fail++; $display("FAIL reset_tx: got %b expected 1", Tx); end
      n_cmp++; if (TxBusy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", TxBusy); end
      n_cmp++; if (Ready !== 1'b1)    begin n_fail++; $display("FAIL reset_ready: got %b expected 1", Ready); end
      n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", Overflow); end
      n_cmp++; if (BadDigit !== 1'b0) begin n_fail++; $display("FAIL reset_bad: got %b expected 0", BadDigit); end
   endtask

   task automatic test_single_char();
      int busy_cnt;
      logic [7:0] got;
      rx_q.delete();
      @(negedge Clk);
      Cout = 1'b1;
      Data = 12'h072;
      @(negedge Clk);                       // after edge N
      Cout = 1'b0;
      n_cmp++; if (Tx !== 1'b1) begin n_fail++; $display("FAIL lat_n: got %b expected 1", Tx); end
      @(negedge Clk);                       // after N+1
      n_cmp++; if (Tx !== 1'b1) begin n_fail++; $display("FAIL lat_n1: got %b expected 1", Tx); end
      @(negedge Clk);                       // after N+2
      n_cmp++; if (Tx !== 1'b1 || TxBusy !== 1'b1) begin
         n_fail++; $display("FAIL lat_n2: got tx=%b busy=%b expected tx=1 busy=1", Tx, TxBusy);
      end
      @(negedge Clk);                       // after N+3
      n_cmp++; if (Tx !== 1'b0) begin n_fail++; $display("FAIL lat_n3: got %b expected 0", Tx); end
      busy_cnt = 1;
      while (TxBusy === 1'b1 && busy_cnt < 200) begin
         busy_cnt++;
         @(negedge Clk);
      end
      n_cmp++; if (busy_cnt !== 40) begin n_fail++; $display("FAIL busy_len: got %0d expected 40", busy_cnt); end
      wait_rx(1, 60);
      got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
      n_cmp++; if (rx_q.size() !== 1 || got !== 8'h48) begin
         n_fail++; $display("FAIL single_byte: got n=%0d b=%h expected n=1 b=48", rx_q.size(), got);
      end
   endtask

   task automatic test_bad_digit();
      logic [7:0] got;
      rx_q.delete();
      send_char(12'h999);
      wait_rx(1, 100);
      got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
      n_cmp++; if (got !== 8'hE7) begin n_fail++; $display("FAIL mod256: got %h expected e7", got); end
      n_cmp++; if (BadDigit !== 1'b0) begin n_fail++; $display("FAIL bad_clean: got %b expected 0", BadDigit); end
      send_char(12'h0A5);
      n_cmp++; if (BadDigit !== 1'b1) begin n_fail++; $display("FAIL bad_set: got %b expected 1", BadDigit); end
      wait_rx(2, 100);
      got = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
      n_cmp++; if (got !== 8'h3F) begin n_fail++; $display("FAIL bad_char: got %h expected 3f", got); end
      send_char(bcd(65));
      wait_rx(3, 100);
      got = (rx_q.size() > 2) ? rx_q[2] : 8'hxx;
      n_cmp++; if (got !== 8'h41) begin n_fail++; $display("FAIL after_bad: got %h expected 41", got); end
      n_cmp++; if (BadDigit !== 1'b1) begin n_fail++; $display("FAIL bad_sticky: got %b expected 1", BadDigit); end
   endtask

   task automatic test_burst();
      logic [7:0] got;
      do_reset();
      rx_q.delete();
      n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL burst_ovf0: got %b expected 0", Overflow); end
      for (int k = 1; k <= 6; k++) begin
         @(negedge Clk);
         if (k == 4) begin
            n_cmp++; if (Ready !== 1'b1) begin n_fail++; $display("FAIL burst_ready3: got %b expected 1", Ready); end
         end
         Cout = 1'b1;
         Data = bcd(k);
      end
      @(negedge Clk);
      Cout = 1'b0;
      n_cmp++; if (Ready !== 1'b0) begin n_fail++; $display("FAIL burst_ready6: got %b expected 0", Ready); end
      @(negedge Clk);
      n_cmp++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL burst_ovf: got %b expected 1", Overflow); end
      wait_rx(5, 320);
      n_cmp++; if (rx_q.size() !== 5) begin n_fail++; $display("FAIL burst_count: got %0d expected 5", rx_q.size()); end
      for (int k = 1; k <= 5; k++) begin
         got = (rx_q.size() >= k) ? rx_q[k-1] : 8'hxx;
         n_cmp++; if (got !== 8'(k)) begin n_fail++; $display("FAIL burst_byte%0d: got %h expected %h", k, got, 8'(k)); end
      end
      repeat (60) @(negedge Clk);
      n_cmp++; if (rx_q.size() !== 5) begin n_fail++; $display("FAIL burst_extra: got %0d expected 5", rx_q.size()); end
      n_cmp++; if (Ready !== 1'b1) begin n_fail++; $display("FAIL burst_ready_end: got %b expected 1", Ready); end
   endtask

   task automatic test_back_to_back();
      logic       tx_h   [48];
      logic       busy_h [48];
      int         cyc;
      int         highs;
      logic [7:0] g0;
      logic [7:0] g1;
      do_reset();
      rx_q.delete();
      send_char(bcd(65));
      send_char(bcd(66));
      cyc = 0;
      while (Tx !== 1'b0 && cyc < 20) begin
         @(negedge Clk);
         cyc++;
      end
      n_cmp++; if (Tx !== 1'b0) begin n_fail++; $display("FAIL b2b_start: got %b expected 0", Tx); end
      for (int i = 0; i < 48; i++) begin
         tx_h[i]   = Tx;
         busy_h[i] = TxBusy;
         @(negedge Clk);
      end
      highs = 0;
      for (int i = 36; i <= 40; i++) if (tx_h[i] === 1'b1) highs++;
      n_cmp++; if (highs !== 5) begin n_fail++; $display("FAIL b2b_gap: got %0d high cycles expected 5", highs); end
      n_cmp++; if (tx_h[41] !== 1'b0) begin n_fail++; $display("FAIL b2b_start2: got %b expected 0", tx_h[41]); end
      n_cmp++; if (busy_h[39] !== 1'b0 || busy_h[40] !== 1'b1) begin
         n_fail++; $display("FAIL b2b_busy: got %b%b expected 01", busy_h[39], busy_h[40]);
      end
      wait_rx(2, 60);
      g0 = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
      g1 = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
      n_cmp++; if (g0 !== 8'h41 || g1 !== 8'h42) begin
         n_fail++; $display("FAIL b2b_bytes: got %h %h expected 41 42", g0, g1);
      end
   endtask

   task automatic test_reset_mid_frame();
      int         cyc;
      int         lows;
      logic [7:0] got;
      do_reset();
      rx_q.delete();
      send_char(12'h0A5);
      send_char(12'h072);
      cyc = 0;
      while (Tx !== 1'b0 && cyc < 20) begin
         @(negedge Clk);
         cyc++;
      end
      repeat (17) @(negedge Clk);           // inside data bit 3
      n_cmp++; if (BadDigit !== 1'b1 || TxBusy !== 1'b1) begin
         n_fail++; $display("FAIL mid_pre: got bad=%b busy=%b expected 1 1", BadDigit, TxBusy);
      end
      Rst = 1'b1;
      @(negedge Clk);
      n_cmp++; if (Tx !== 1'b1 || TxBusy !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_line: got tx=%b busy=%b expected 1 0", Tx, TxBusy);
      end
      n_cmp++; if (BadDigit !== 1'b0 || Overflow !== 1'b0 || Ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_rst_flags: got bad=%b ovf=%b rdy=%b expected 0 0 1", BadDigit, Overflow, Ready);
      end
      @(negedge Clk);
      Rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge Clk);
         if (Tx !== 1'b1) lows++;
      end
      n_cmp++; if (lows !== 0 || rx_q.size() !== 0) begin
         n_fail++; $display("FAIL mid_fifo_empty: got lows=%0d rx=%0d expected 0 0", lows, rx_q.size());
      end
      send_char(12'h072);
      wait_rx(1, 60);
      got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
      n_cmp++; if (got !== 8'h48) begin n_fail++; $display("FAIL mid_after: got %h expected 48", got); end
   endtask

   task automatic test_wrap();
      logic [7:0] got;
      do_reset();
      rx_q.delete();
      for (int k = 1; k <= 20; k++) begin
         send_char(bcd(k * 47));
         repeat (42) @(negedge Clk);
      end
      wait_rx(20, 100);
      n_cmp++; if (rx_q.size() !== 20) begin n_fail++; $display("FAIL wrap_count: got %0d expected 20", rx_q.size()); end
      for (int k = 1; k <= 20; k++) begin
         got = (rx_q.size() >= k) ? rx_q[k-1] : 8'hxx;
         n_cmp++; if (got !== 8'(k * 47)) begin
            n_fail++; $display("FAIL wrap_byte%0d: got %h expected %h", k, got, 8'(k * 47));
         end
      end
      n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 0", Overflow); end
   endtask

   initial begin : main
      test_reset();
      test_single_char();
      test_bad_digit();
      test_burst();
      test_back_to_back();
      test_reset_mid_frame();
      test_wrap();
      n_cmp++; if (frame_err !== 0) begin n_fail++; $display("FAIL framing: got %0d errors expected 0", frame_err); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
